// File: rtl/usb_line_packetizer.sv
// usb_line_packetizer: turns Avalon-ST pixel lines into framed USB byte packets
// (A5 5A line_num len payload checksum) written over Avalon-MM. Byte writes
// are gated by a credit count polled from the downstream TX FIFO.
module usb_line_packetizer #(
  parameter int TX_DEPTH = 512,
  parameter int USEDW_W  = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cfg_line_len,
  input  logic [15:0] snk_data,
  input  logic        snk_valid,
  output logic        snk_ready,
  input  logic        snk_sop,
  input  logic        snk_eop,
  output logic [3:0]  avm_address,
  output logic        avm_read,
  input  logic [7:0]  avm_readdata,
  output logic        avm_write,
  output logic [7:0]  avm_writedata,
  output logic [15:0] line_num,
  output logic        err_short,
  output logic        err_long,
  output logic        busy
);
  localparam int CW = USEDW_W + 1;

  typedef enum logic [3:0] {
    IDLE, POLL_L, WAIT_L, POLL_H, WAIT_H, HDR, PAY_LO, PAY_HI, CSUM, DRAIN
  } state_t;

  state_t        state, state_nx, ret_state;
  logic [CW-1:0] credit, credit_rd;
  logic [7:0]    usedw_lo, hdr_byte, hi_byte, csum, wdata;
  logic [15:0]   len, pix_cnt;
  logic [2:0]    hdr_idx;
  logic          eop_seen, wr, rd, rdy, go_poll, accept;
  logic [3:0]    addr;

  // credit implied by the usedw high read; zero when the FIFO reports full
  always_comb begin
    credit_rd = '0;
    if (avm_readdata[7])
      credit_rd = CW'(TX_DEPTH - 1) - CW'({avm_readdata[0], usedw_lo});
  end

  // header byte selected by position within the 6-byte header
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0:    hdr_byte = 8'hA5;
      3'd1:    hdr_byte = 8'h5A;
      3'd2:    hdr_byte = line_num[7:0];
      3'd3:    hdr_byte = line_num[15:8];
      3'd4:    hdr_byte = len[7:0];
      default: hdr_byte = len[15:8];
    endcase
  end

  // next-state and bus strobes; any byte state lacking credit detours to a poll
  always_comb begin
    state_nx = state;
    wr       = 1'b0;
    wdata    = 8'h00;
    rd       = 1'b0;
    addr     = 4'd0;
    rdy      = 1'b0;
    go_poll  = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        rdy = !(snk_valid && snk_sop);
        if (snk_valid && snk_sop) state_nx = HDR;
      end
      POLL_L: begin rd = 1'b1; addr = 4'd2; state_nx = WAIT_L; end
      WAIT_L: state_nx = POLL_H;
      POLL_H: begin rd = 1'b1; addr = 4'd3; state_nx = WAIT_H; end
      WAIT_H: state_nx = (credit_rd != '0) ? ret_state : POLL_L;
      HDR: begin
        if (credit == '0) go_poll = 1'b1;
        else begin
          wr    = 1'b1;
          wdata = hdr_byte;
          if (hdr_idx == 3'd5) state_nx = (len == 16'd0) ? CSUM : PAY_LO;
        end
      end
      PAY_LO: begin
        if (credit == '0) go_poll = 1'b1;
        else if (eop_seen) begin
          wr       = 1'b1;
          state_nx = PAY_HI;
        end else begin
          rdy = 1'b1;
          if (snk_valid) begin
            accept   = 1'b1;
            wr       = 1'b1;
            wdata    = snk_data[7:0];
            state_nx = PAY_HI;
          end
        end
      end
      PAY_HI: begin
        if (credit == '0) go_poll = 1'b1;
        else begin
          wr       = 1'b1;
          wdata    = hi_byte;
          state_nx = (pix_cnt + 16'd1 == len) ? CSUM : PAY_LO;
        end
      end
      CSUM: begin
        if (credit == '0) go_poll = 1'b1;
        else begin
          wr       = 1'b1;
          wdata    = csum;
          state_nx = eop_seen ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        rdy = 1'b1;
        if (snk_valid && snk_eop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (go_poll) state_nx = POLL_L;
  end

  // state, credit, packet position and checksum registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ret_state <= IDLE;
      credit    <= '0;
      usedw_lo  <= 8'h00;
      len       <= 16'd0;
      pix_cnt   <= 16'd0;
      hdr_idx   <= 3'd0;
      hi_byte   <= 8'h00;
      csum      <= 8'h00;
      eop_seen  <= 1'b0;
      line_num  <= 16'd0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      state <= state_nx;
      if (go_poll) ret_state <= state;
      if (state == WAIT_L) usedw_lo <= avm_readdata;
      if (state == WAIT_H) credit <= credit_rd;
      else if (wr)         credit <= credit - CW'(1);
      if (state == IDLE && snk_valid && snk_sop) begin
        len      <= cfg_line_len;
        pix_cnt  <= 16'd0;
        hdr_idx  <= 3'd0;
        csum     <= 8'h00;
        eop_seen <= 1'b0;
      end
      if (wr && state == HDR) hdr_idx <= hdr_idx + 3'd1;
      // checksum covers everything after the A5 5A sync bytes, up to the payload end
      if (wr && ((state == HDR && hdr_idx >= 3'd2) || state == PAY_LO || state == PAY_HI))
        csum <= csum + wdata;
      if (wr && state == PAY_LO) begin
        hi_byte <= accept ? snk_data[15:8] : 8'h00;
        if (accept && snk_eop) begin
          eop_seen <= 1'b1;
          if (pix_cnt + 16'd1 < len) err_short <= 1'b1;
        end
      end
      if (wr && state == PAY_HI) pix_cnt <= pix_cnt + 16'd1;
      if (wr && state == CSUM) begin
        line_num <= line_num + 16'd1;
        if (!eop_seen && len != 16'd0) err_long <= 1'b1;
      end
      // zero-length line: any beat other than a lone sop+eop is an overrun
      if (state == DRAIN && snk_valid && !snk_eop && len == 16'd0) err_long <= 1'b1;
    end
  end

  assign snk_ready     = rdy && !reset;
  assign avm_read      = rd && !reset;
  assign avm_write     = wr && !reset;
  assign avm_address   = addr;
  assign avm_writedata = wdata;
  assign busy          = !reset && state != IDLE && state != DRAIN;
endmodule
